drawing_arbiter: RTL and testbench
==================================

Name: drawing_arbiter

Overview:
- Parametrised N-channel arbiter that merges drawing-engine memory requesters onto the single drawing-engine memory port (de_*).
- It succeeds the fixed 4-channel combinational mux. The forward path is now registered per transaction, so the mux cannot glitch.
- Arbitration mode is selectable: fixed priority or round-robin.
- Acks are steered using the latched grant.

Parameters:
- NCH, 4: number of requesting channels (2..8).
- AW, 18: address width.
- DW, 32: data width.
- NBW, 4: byte-enable (nbyte) width, active low.
- RR, 0: arbitration mode; 0 = fixed priority (channel 0 highest), 1 = round-robin.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NCH  per-channel request; level, held until that channel's ack.
- ack  out  NCH  per-channel acknowledge; one-cycle pulse.
- rnw  in  NCH  per-channel read-not-write.
- addr  in  NCH*AW  per-channel address; channel i occupies bits [i*AW +: AW].
- nbyte  in  NCH*NBW  per-channel byte strobes, active low.
- data  in  NCH*DW  per-channel write data.
- rd_data  out  DW  read data, broadcast to all channels; valid in the cycle ack is high.
- de_req  out  1  request to the memory driver.
- de_ack  in  1  one-cycle completion pulse from the memory driver.
- de_rnw  out  1  registered rnw of the granted channel.
- de_addr  out  AW  registered address of the granted channel.
- de_nbyte  out  NBW  registered byte strobes of the granted channel.
- de_data  out  DW  registered write data of the granted channel.
- de_rd_data  in  DW  read data from the memory driver.

Behaviour:
- Reset values:
  - state = IDLE; de_req = 0; ack = 0.
  - de_rnw = 1; de_addr, de_nbyte, de_data = 0.
  - grant = 0; round-robin pointer = NCH-1, so channel 0 wins first.
- rst mid-transaction aborts it with no ack; a late de_ack after reset is ignored.
- FSM states: IDLE, BUSY, RECOVER.
- IDLE:
  - If any req bit is high, pick a winner, latch its rnw/addr/nbyte/data into the de_* registers, record grant, go to BUSY.
  - de_req rises on the following edge (1-cycle request-to-de_req latency).
  - If req is all zero, stay in IDLE.
- BUSY:
  - de_req = 1; the de_* outputs are held stable.
  - When de_ack = 1, ack[grant] = 1 combinationally in the same cycle and rd_data = de_rd_data; go to RECOVER.
  - de_req drops in RECOVER.
- RECOVER:
  - One-cycle bubble so the acked requester can drop or change req before re-arbitration. Go to IDLE.
  - Minimum transaction period is 3 cycles plus memory latency.
- Arbitration:
  - RR=0: lowest-index active req wins.
  - RR=1: search starts at pointer+1, modulo NCH; the pointer updates to grant only on ack.
- Boundary conditions:
  - req[grant] dropping while in BUSY: the transaction still completes and ack still pulses.
  - de_ack in IDLE or RECOVER: ignored; no ack pulses.
  - Simultaneous requests: exactly one grant per transaction; ack is always one-hot or zero.
  - Inputs of non-granted channels may change freely in any state without affecting the de_* outputs.
  - rd_data is a pure wire from de_rd_data (no latency).

Optional Feature:
- Macro: DRAWING_ARB_LOCK_EN.
- Enabled:
  - Extra input port lock, NCH bits.
  - If lock[grant] = 1 in the ack cycle, the next IDLE arbitration grants the same channel, bypassing priority and pointer, provided req[grant] = 1. Otherwise normal arbitration applies.
  - Lock is held at most 16 consecutive transactions; then normal arbitration is forced for one decision.
- Disabled: no lock port; behaviour is exactly as described above.

Decomposition:
- Shared include/package drawing_defs:
  - FSM state encodings IDLE=2'd0, BUSY=2'd1, RECOVER=2'd2.
  - clog2 function for the grant width.
  - LOCK_MAX=16 constant.
- One sub-module: drawing_arb_pick.
  - Combinational.
  - Inputs: req vector, pointer, mode.
  - Outputs: winner index and a valid flag.

Test Plan:
- Reset then single request: NCH=4, RR=0, req=4'b0100 with addr2=18'h0ABC, rnw2=0, data2=32'hDEADBEEF → one edge later de_req=1, de_addr=18'h0ABC, de_data=32'hDEADBEEF; de_ack pulse → ack=4'b0100 in the same cycle, de_req=0 next cycle.
- Fixed priority: req=4'b1111 held, RR=0 → grant order 0,0,0,... while req0 stays high; drop req0 after its ack → next grant 1.
- Round-robin: RR=1, req=4'b1011 held → grant order 0,1,3,0,1,3; ack is never 4'b0100.
- Read path: rnw1=1, de_rd_data=32'h12345678 with de_ack → rd_data=32'h12345678 and ack[1]=1 in the same cycle.
- Spurious and reset cases:
  - de_ack in IDLE → ack=0.
  - rst asserted in BUSY → next cycle de_req=0, ack=0, state IDLE, a subsequent de_ack is ignored, and pointer=NCH-1.
- DRAWING_ARB_LOCK_EN: RR=1, req=4'b0011, lock[1]=1 → after channel 1 wins, it is regranted for 16 transactions, then channel 0 gets the next grant.

Source files
------------

// File: rtl/drawing_arbiter_pkg.sv
// +----------------------------------------------------------------------------+
// | Module   : drawing_defs (package)                                          |
// | Brief    : Shared FSM encodings, lock limit and clog2 helper for the        |
// |            drawing-engine memory arbiter.                                   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

package drawing_defs;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RECOVER = 2'd2
    } state_t;

    localparam int LOCK_MAX = 16;

    // Minimum of 1 bit so a 2-channel arbiter still has a usable grant index.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 16; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/drawing_arb_pick.sv
// +----------------------------------------------------------------------------+
// | Module   : drawing_arb_pick                                                |
// | Brief    : Combinational winner search: lowest index in fixed mode, or     |
// |            first active request after the pointer in round-robin mode.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module drawing_arb_pick #(
    parameter int NCH = 4,
    parameter int GW  = 2
) (
    input  logic [NCH-1:0] req,
    input  logic [GW-1:0]  ptr,
    input  logic           mode,
    output logic [GW-1:0]  winner,
    output logic           valid
);

    logic [GW-1:0] w_idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        w_idx  = '0;
        for (int k = 0; k < NCH; k++) begin
            w_idx = mode ? GW'((int'(ptr) + 1 + k) % NCH) : GW'(k);
            if (!valid && req[w_idx]) begin
                winner = w_idx;
                valid  = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/drawing_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module   : drawing_arbiter                                                 |
// | Brief    : N-channel arbiter merging drawing-engine requesters onto the    |
// |            de_* memory port with a registered forward path.                |
// |            Optional grant lock enabled by DRAWING_ARB_LOCK_EN.             |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module drawing_arbiter
    import drawing_defs::*;
#(
    parameter int NCH = 4,
    parameter int AW  = 18,
    parameter int DW  = 32,
    parameter int NBW = 4,
    parameter int RR  = 0
) (
    input  logic               clk,
    input  logic               rst,
`ifdef DRAWING_ARB_LOCK_EN
    input  logic [NCH-1:0]     lock,
`endif
    input  logic [NCH-1:0]     req,
    output logic [NCH-1:0]     ack,
    input  logic [NCH-1:0]     rnw,
    input  logic [NCH*AW-1:0]  addr,
    input  logic [NCH*NBW-1:0] nbyte,
    input  logic [NCH*DW-1:0]  data,
    output logic [DW-1:0]      rd_data,
    output logic               de_req,
    input  logic               de_ack,
    output logic               de_rnw,
    output logic [AW-1:0]      de_addr,
    output logic [NBW-1:0]     de_nbyte,
    output logic [DW-1:0]      de_data,
    input  logic [DW-1:0]      de_rd_data
);

    localparam int   c_gw      = clog2(NCH);
    localparam logic c_rr_mode = (RR != 0);

    state_t          r_state;
    state_t          w_next_state;
    logic [c_gw-1:0] r_grant;
    logic [c_gw-1:0] r_ptr;
    logic            r_de_req;
    logic            r_de_rnw;
    logic [AW-1:0]   r_de_addr;
    logic [NBW-1:0]  r_de_nbyte;
    logic [DW-1:0]   r_de_data;
    logic [NCH-1:0]  w_ack;

    logic [c_gw-1:0] w_pick_idx;
    logic            w_pick_valid;
    logic [c_gw-1:0] w_sel;
    logic            w_sel_valid;
    logic            w_use_lock;

    logic [AW-1:0]   w_addr_a  [NCH];
    logic [NBW-1:0]  w_nbyte_a [NCH];
    logic [DW-1:0]   w_data_a  [NCH];

    for (genvar i = 0; i < NCH; i++) begin : g_unpack
        assign w_addr_a[i]  = addr[i*AW +: AW];
        assign w_nbyte_a[i] = nbyte[i*NBW +: NBW];
        assign w_data_a[i]  = data[i*DW +: DW];
    end

    drawing_arb_pick #(
        .NCH (NCH),
        .GW  (c_gw)
    ) u_pick (
        .req    (req),
        .ptr    (r_ptr),
        .mode   (c_rr_mode),
        .winner (w_pick_idx),
        .valid  (w_pick_valid)
    );

`ifdef DRAWING_ARB_LOCK_EN
    logic       r_lock_pend;
    logic [4:0] r_lock_cnt;

    // A locked channel is re-granted only while it still requests and the run limit is not hit.
    assign w_use_lock = r_lock_pend && req[r_grant] && (r_lock_cnt < 5'(LOCK_MAX));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lock_pend <= 1'b0;
            r_lock_cnt  <= 5'd0;
        end else begin
            if (r_state == BUSY && de_ack) r_lock_pend <= lock[r_grant];
            if (r_state == IDLE && w_sel_valid)
                r_lock_cnt <= w_use_lock ? r_lock_cnt + 5'd1 : 5'd0;
        end
    end
`else
    assign w_use_lock = 1'b0;
`endif

    assign w_sel       = w_use_lock ? r_grant : w_pick_idx;
    assign w_sel_valid = w_use_lock | w_pick_valid;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_ack        = '0;
        unique case (r_state)
            IDLE:    if (w_sel_valid) w_next_state = BUSY;
            BUSY: begin
                if (de_ack) begin
                    w_next_state   = RECOVER;
                    w_ack[r_grant] = 1'b1;
                end
            end
            RECOVER: w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant    <= '0;
            r_ptr      <= c_gw'(NCH - 1);
            r_de_req   <= 1'b0;
            r_de_rnw   <= 1'b1;
            r_de_addr  <= '0;
            r_de_nbyte <= '0;
            r_de_data  <= '0;
        end else begin
            r_de_req <= (w_next_state == BUSY);
            if (r_state == IDLE && w_sel_valid) begin
                r_grant    <= w_sel;
                r_de_rnw   <= rnw[w_sel];
                r_de_addr  <= w_addr_a[w_sel];
                r_de_nbyte <= w_nbyte_a[w_sel];
                r_de_data  <= w_data_a[w_sel];
            end
            // Pointer advances only on completion, so an aborted grant does not cost a turn.
            if (r_state == BUSY && de_ack) r_ptr <= r_grant;
        end
    end

    assign ack      = w_ack;
    assign rd_data  = de_rd_data;
    assign de_req   = r_de_req;
    assign de_rnw   = r_de_rnw;
    assign de_addr  = r_de_addr;
    assign de_nbyte = r_de_nbyte;
    assign de_data  = r_de_data;

endmodule

`default_nettype wire

// File: tb/tb_drawing_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_drawing_arbiter                                              |
// | Brief    : Self-checking bench: fixed-priority and round-robin instances   |
// |            against a transaction-level reference model.                    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_drawing_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req [2];
    logic [3:0]  ack [2];
    logic [3:0]  rnw [2];
    logic [3:0]  lk  [2];
    logic [71:0] addr [2];
    logic [15:0] nbyte [2];
    logic [127:0] data [2];
    logic [31:0] rd_data [2];
    logic        de_req [2];
    logic        de_ack [2];
    logic        de_rnw [2];
    logic [17:0] de_addr [2];
    logic [3:0]  de_nbyte [2];
    logic [31:0] de_data [2];
    logic [31:0] de_rd_data [2];

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    // Instance 0 is fixed priority, instance 1 is round-robin.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        drawing_arbiter #(
            .NCH (4), .AW (18), .DW (32), .NBW (4), .RR (g)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
`ifdef DRAWING_ARB_LOCK_EN
            .lock       (lk[g]),
`endif
            .req        (req[g]),
            .ack        (ack[g]),
            .rnw        (rnw[g]),
            .addr       (addr[g]),
            .nbyte      (nbyte[g]),
            .data       (data[g]),
            .rd_data    (rd_data[g]),
            .de_req     (de_req[g]),
            .de_ack     (de_ack[g]),
            .de_rnw     (de_rnw[g]),
            .de_addr    (de_addr[g]),
            .de_nbyte   (de_nbyte[g]),
            .de_data    (de_data[g]),
            .de_rd_data (de_rd_data[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    bit          m_busy [2];
    bit          m_rec  [2];
    int          m_gnt  [2];
    int          m_ptr  [2];
    logic        m_rnw  [2];
    logic [17:0] m_addr [2];
    logic [3:0]  m_nby  [2];
    logic [31:0] m_dat  [2];
    bit          m_lpend [2];
    int          m_lcnt [2];

    function automatic int pick(input logic [3:0] r, input int ptr, input bit rr);
        for (int k = 0; k < 4; k++) begin
            int c;
            c = rr ? (ptr + 1 + k) % 4 : k;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    initial forever begin
        @(posedge clk);
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                m_busy[m] = 0; m_rec[m] = 0; m_gnt[m] = 0; m_ptr[m] = 3;
                m_rnw[m] = 1'b1; m_addr[m] = '0; m_nby[m] = '0; m_dat[m] = '0;
                m_lpend[m] = 0; m_lcnt[m] = 0;
            end else if (m_busy[m]) begin
                if (de_ack[m]) begin
                    m_busy[m]  = 0;
                    m_rec[m]   = 1;
                    m_ptr[m]   = m_gnt[m];
                    m_lpend[m] = lk[m][m_gnt[m]];
                end
            end else if (m_rec[m]) begin
                m_rec[m] = 0;
            end else begin : arb
                int  w;
                bit  locked;
                locked = m_lpend[m] && req[m][m_gnt[m]] && (m_lcnt[m] < 16);
                w = locked ? m_gnt[m] : pick(req[m], m_ptr[m], m == 1);
                if (w >= 0) begin
                    m_lcnt[m] = locked ? m_lcnt[m] + 1 : 0;
                    m_gnt[m]  = w;
                    m_busy[m] = 1;
                    m_rnw[m]  = rnw[m][w];
                    m_addr[m] = addr[m][w*18 +: 18];
                    m_nby[m]  = nbyte[m][w*4 +: 4];
                    m_dat[m]  = data[m][w*32 +: 32];
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            for (int m = 0; m < 2; m++) begin : cmp
                logic [3:0] ea;
                ea = (m_busy[m] && de_ack[m]) ? 4'(1 << m_gnt[m]) : 4'b0000;
                chk("de_req",   de_req[m],   m_busy[m]);
                chk("ack",      ack[m],      ea);
                chk("de_rnw",   de_rnw[m],   m_rnw[m]);
                chk("de_addr",  de_addr[m],  m_addr[m]);
                chk("de_nbyte", de_nbyte[m], m_nby[m]);
                chk("de_data",  de_data[m],  m_dat[m]);
                chk("rd_data",  rd_data[m],  de_rd_data[m]);
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic wait_busy(input int m);
        for (int n = 0; n < 20; n++) begin
            if (de_req[m]) return;
            cyc();
        end
        checks++;
        errors++;
        $display("FAIL wait_busy instance %0d: de_req never rose within 20 cycles", m);
    endtask

    task automatic txn(input int m, output logic [3:0] a);
        wait_busy(m);
        de_ack[m] = 1'b1;
        #1 a = ack[m];
        cyc();
        de_ack[m] = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] a;
        logic [3:0] seen [2];
        rst = 1'b1;
        for (int m = 0; m < 2; m++) begin
            req[m] = '0; rnw[m] = '1; lk[m] = '0; addr[m] = '0; nbyte[m] = '0;
            data[m] = '0; de_ack[m] = 1'b0; de_rd_data[m] = '0;
        end
        repeat (3) @(posedge clk);
        #1 cmp_en = 1;
        chk("rst_de_req", de_req[0], 1'b0);
        chk("rst_ack",    ack[0],    4'b0000);
        chk("rst_de_rnw", de_rnw[0], 1'b1);
        chk("rst_de_addr", de_addr[0], 18'h0);
        rst = 1'b0;

        // Single request on channel 2
        req[0] = 4'b0100; rnw[0] = 4'b1011;
        addr[0][36 +: 18] = 18'h0ABC; data[0][64 +: 32] = 32'hDEADBEEF;
        cyc();
        chk("single_de_req",  de_req[0],  1'b1);
        chk("single_de_addr", de_addr[0], 18'h0ABC);
        chk("single_de_data", de_data[0], 32'hDEADBEEF);
        chk("single_de_rnw",  de_rnw[0],  1'b0);
        de_ack[0] = 1'b1;
        #1 chk("single_ack", ack[0], 4'b0100);
        cyc();
        de_ack[0] = 1'b0; req[0] = 4'b0000;
        chk("single_de_req_drop", de_req[0], 1'b0);

        // Fixed priority
        req[0] = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            txn(0, a);
            chk("fp_ch0", a, 4'b0001);
        end
        req[0] = 4'b1110;
        txn(0, a);
        chk("fp_ch1", a, 4'b0010);
        req[0] = 4'b0000;

        // Read path
        repeat (2) cyc();
        rnw[0] = 4'b0010; req[0] = 4'b0010; de_rd_data[0] = 32'h12345678;
        wait_busy(0);
        de_ack[0] = 1'b1;
        #1;
        chk("read_rd_data", rd_data[0], 32'h12345678);
        chk("read_ack1",    ack[0][1],  1'b1);
        cyc();
        de_ack[0] = 1'b0; req[0] = 4'b0000;

        // Spurious de_ack in IDLE
        repeat (2) cyc();
        de_ack[0] = 1'b1;
        #1 chk("idle_ack", ack[0], 4'b0000);
        cyc();
        de_ack[0] = 1'b0;
        chk("idle_de_req", de_req[0], 1'b0);

        // Round-robin
        do_reset();
        req[1] = 4'b1011;
        for (int i = 0; i < 6; i++) begin
            txn(1, a);
            case (i % 3)
                0: chk("rr_seq", a, 4'b0001);
                1: chk("rr_seq", a, 4'b0010);
                default: chk("rr_seq", a, 4'b1000);
            endcase
        end
        req[1] = 4'b0000;

        // Reset while BUSY
        do_reset();
        req[1] = 4'b0001;
        txn(1, a);
        chk("rst_pre", a, 4'b0001);
        req[1] = 4'b0010;
        wait_busy(1);
        rst = 1'b1;
        cyc();
        rst = 1'b0; req[1] = 4'b0000;
        chk("rst_busy_de_req", de_req[1], 1'b0);
        de_ack[1] = 1'b1;
        #1 chk("rst_late_ack", ack[1], 4'b0000);
        cyc();
        de_ack[1] = 1'b0;
        chk("rst_stay_idle", de_req[1], 1'b0);
        req[1] = 4'b0011;
        txn(1, a);
        chk("rst_ptr_reset", a, 4'b0001);
        req[1] = 4'b0000;

`ifdef DRAWING_ARB_LOCK_EN
        do_reset();
        lk[1] = 4'b0010; req[1] = 4'b0011;
        txn(1, a);
        chk("lock_first", a, 4'b0001);
        for (int i = 0; i < 17; i++) begin
            txn(1, a);
            chk("lock_hold", a, 4'b0010);
        end
        txn(1, a);
        chk("lock_release", a, 4'b0001);
        req[1] = 4'b0000; lk[1] = 4'b0000;
`endif

        // Randomized traffic, including spurious acks, abandoned requests and resets
        for (int t = 0; t < 4000; t++) begin
            @(negedge clk);
            for (int m = 0; m < 2; m++) seen[m] = ack[m];
            @(posedge clk);
            #1;
            rst = ($urandom_range(0, 299) == 0);
            for (int m = 0; m < 2; m++) begin
                for (int c = 0; c < 4; c++) begin
                    if (!req[m][c]) begin
                        if ($urandom_range(0, 3) == 0) req[m][c] = 1'b1;
                    end else if (seen[m][c]) begin
                        if ($urandom_range(0, 1) == 0) req[m][c] = 1'b0;
                    end else if ($urandom_range(0, 63) == 0) begin
                        req[m][c] = 1'b0;
                    end
                end
                rnw[m]        = 4'($urandom);
                addr[m]       = 72'({$urandom, $urandom, $urandom});
                nbyte[m]      = 16'($urandom);
                data[m]       = {$urandom, $urandom, $urandom, $urandom};
                de_rd_data[m] = $urandom;
                de_ack[m]     = ($urandom_range(0, 2) == 0);
`ifdef DRAWING_ARB_LOCK_EN
                lk[m]         = 4'($urandom);
`endif
            end
        end

        rst = 1'b0;
        for (int m = 0; m < 2; m++) begin
            req[m] = '0; de_ack[m] = 1'b0;
        end
        repeat (4) cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
